// File: rtl/sha_round_ctrl_if.sv
// SHA shared types and the round-controller to main-loop datapath interface.
// The controller is the master; the compression datapath answers with ripe.
package sha;
  typedef logic [63:0] word_t;
  typedef word_t [7:0] mainloop_word_t;
  typedef enum logic [1:0] {
    MODE_224,
    MODE_256,
    MODE_384,
    MODE_512
  } mode_t;
endpackage

interface sha_mainloop_if;
  import sha::*;
  logic           enable;
  mode_t          mode;
  word_t          k;
  word_t          w;
  mainloop_word_t raw;
  mainloop_word_t ripe;

  modport master (
    output enable, mode, k, w, raw,
    input  ripe
  );
  modport slave (
    input  enable, mode, k, w, raw,
    output ripe
  );
endinterface

// File: rtl/sha_round_ctrl.sv
// Round sequencer for the SHA compression main loop.
// Fetches (k, w) per round, issues it, waits out the datapath latency.
module sha_round_ctrl
  import sha::*;
#(
  parameter int ML_LATENCY = 1,
  parameter int RND_W      = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  mode_t              mode_i,
  input  mainloop_word_t     init_i,
  output logic               busy,
  output logic               done,
  output mainloop_word_t     digest_o,
  output logic [RND_W-1:0]   round_o,
  output logic               sched_req,
  input  word_t              sched_k,
  input  word_t              sched_w,
  input  logic               sched_valid,
  sha_mainloop_if.master     ml
);

  localparam int LAT_W =
    (ML_LATENCY > 1) ? $clog2(ML_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT =
    LAT_W'(ML_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_st;
  mode_t            r_mode;
  mainloop_word_t   r_state;
  mainloop_word_t   r_digest;
  word_t            r_k;
  word_t            r_w;
  logic             r_en;
  logic             r_busy;
  logic             r_req;
  logic             r_done;
  logic [LAT_W-1:0] r_cnt;
  logic [RND_W-1:0] r_rnd;

  logic             w_long;
  logic [RND_W-1:0] w_last;
  logic             w_abort;

  assign w_long  = (r_mode == MODE_384) ||
                   (r_mode == MODE_512);
  assign w_last  = w_long ? RND_W'(79) : RND_W'(63);
  assign w_abort = abort && (r_st != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st     <= S_IDLE;
      r_mode   <= mode_t'('0);
      r_state  <= '0;
      r_digest <= '0;
      r_k      <= '0;
      r_w      <= '0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_req    <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_rnd    <= '0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      if (w_abort) begin
        r_st   <= S_IDLE;
        r_busy <= 1'b0;
        r_req  <= 1'b0;
      end else begin
        unique case (r_st)
          S_IDLE: begin
            if (start) begin
              r_mode  <= mode_i;
              r_state <= init_i;
              r_rnd   <= '0;
              r_busy  <= 1'b1;
              r_req   <= 1'b1;
              r_st    <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (sched_valid) begin
              r_k   <= sched_k;
              r_w   <= sched_w;
              r_req <= 1'b0;
              r_en  <= 1'b1;
              r_st  <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_cnt <= LAT_INIT;
            r_st  <= S_WAIT;
          end
          S_WAIT: begin
            if (r_cnt == '0) begin
              r_state <= ml.ripe;
              if (r_rnd == w_last) begin
                r_done <= 1'b1;
                r_st   <= S_DONE;
              end else begin
                r_rnd <= r_rnd + 1'b1;
                r_req <= 1'b1;
                r_st  <= S_FETCH;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DONE: begin
            r_digest <= r_state;
            r_busy   <= 1'b0;
            r_st     <= S_IDLE;
          end
          default: r_st <= S_IDLE;
        endcase
      end
    end
  end

  // A late abort in DONE must still hide the pulse it cancels.
  assign done      = r_done && !abort;
  assign busy      = r_busy;
  assign sched_req = r_req;
  assign round_o   = r_rnd;
  assign digest_o  = r_digest;

  assign ml.enable = r_en;
  assign ml.mode   = r_mode;
  assign ml.k      = r_k;
  assign ml.w      = r_w;
  assign ml.raw    = r_state;

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Directed bench for sha_round_ctrl with a one-cycle main-loop stand-in.
// Expected digests come from a behavioural round model.
module tb_sha_round_ctrl;
  import sha::*;

  localparam int ML_LATENCY = 1;
  localparam int RND_W      = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  mode_t            mode_i = MODE_256;
  mainloop_word_t   init_i = '0;
  logic             busy;
  logic             done;
  mainloop_word_t   digest_o;
  logic [RND_W-1:0] round_o;
  logic             sched_req;
  word_t            sched_k;
  word_t            sched_w;
  logic             sched_valid = 1'b1;

  sha_mainloop_if ml_if();

  sha_round_ctrl #(
    .ML_LATENCY(ML_LATENCY),
    .RND_W(RND_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .mode_i(mode_i),
    .init_i(init_i),
    .busy(busy),
    .done(done),
    .digest_o(digest_o),
    .round_o(round_o),
    .sched_req(sched_req),
    .sched_k(sched_k),
    .sched_w(sched_w),
    .sched_valid(sched_valid),
    .ml(ml_if.master)
  );

  always #5 clk = ~clk;

  function automatic word_t kconst(int r);
    return 64'h428A2F98D728AE22 + 64'(r) * 64'h9E3779B97F4A7C15;
  endfunction

  function automatic word_t wconst(int r);
    return {32'(r) ^ 32'hA5A50000, 32'hDEAD0000 | 32'(r * 7)};
  endfunction

  function automatic mainloop_word_t ml_f(mainloop_word_t s,
                                          word_t k, word_t w);
    mainloop_word_t n;
    n[7:1] = s[6:0];
    n[0]   = s[7] + {s[3][31:0], s[3][63:32]} + k + w;
    return n;
  endfunction

  function automatic mainloop_word_t model(mode_t m,
                                           mainloop_word_t s0);
    mainloop_word_t s;
    int last;
    s = s0;
    last = (m == MODE_384 || m == MODE_512) ? 79 : 63;
    for (int r = 0; r <= last; r++)
      s = ml_f(s, kconst(r), wconst(r));
    return s;
  endfunction

  always_comb begin
    sched_k = kconst(int'(round_o));
    sched_w = wconst(int'(round_o));
  end

  always @(posedge clk)
    if (ml_if.enable)
      ml_if.ripe <= ml_f(ml_if.raw, ml_if.k, ml_if.w);

  int errors = 0;
  int checks = 0;

  int done_cyc, n_done, n_en, first_busy, last_busy, n_busy;
  int rnd_bad, max_rnd, mode_bad, stall_req, stall_en;
  logic busy_log [0:399];

  mainloop_word_t I1, I2, I3, exp_d, prev_d;

  task automatic run(input mode_t m, input mainloop_word_t ini,
                     input int stall_rnd, input int stall_len,
                     input int abort_cyc, input int bstart_cyc,
                     input int ncyc);
    int prev_rnd;
    int left;
    logic stalled;
    done_cyc = -1; n_done = 0; n_en = 0;
    first_busy = -1; last_busy = -1; n_busy = 0;
    rnd_bad = 0; max_rnd = 0; mode_bad = 0;
    stall_req = 0; stall_en = 0;
    prev_rnd = 0;
    left = stall_len;
    for (int i = 0; i < 400; i++) busy_log[i] = 1'b0;
    @(posedge clk); #1;
    mode_i = m;
    init_i = ini;
    start = 1'b1;
    abort = (abort_cyc == 0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == bstart_cyc);
      abort = (c == abort_cyc);
      sched_valid = 1'b1;
      stalled = 1'b0;
      if (left > 0 && sched_req && int'(round_o) == stall_rnd) begin
        sched_valid = 1'b0;
        stalled = 1'b1;
        left--;
      end
      @(negedge clk);
      busy_log[c] = busy;
      if (busy) begin
        if (first_busy < 0) first_busy = c;
        last_busy = c;
        n_busy++;
        if (ml_if.mode !== m) mode_bad++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (ml_if.enable) n_en++;
      if (stalled && sched_req && int'(round_o) == stall_rnd)
        stall_req++;
      if (stalled && ml_if.enable) stall_en++;
      if (int'(round_o) != prev_rnd) begin
        if (int'(round_o) != prev_rnd + 1) rnd_bad++;
        prev_rnd = int'(round_o);
      end
      if (int'(round_o) > max_rnd) max_rnd = int'(round_o);
    end
    start = 1'b0;
    abort = 1'b0;
    sched_valid = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, sched_req, ml_if.enable} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {busy, done, sched_req, ml_if.enable});
    end
    checks++;
    if (round_o !== '0) begin
      errors++;
      $display("FAIL reset_round got=%0d exp=0", round_o);
    end
    checks++;
    if (digest_o !== '0 || ml_if.raw !== '0) begin
      errors++;
      $display("FAIL reset_state digest/raw not zero");
    end
    checks++;
    if (ml_if.k !== '0 || ml_if.w !== '0 ||
        ml_if.mode !== MODE_224) begin
      errors++;
      $display("FAIL reset_ml k=%h w=%h mode=%0d exp zero",
               ml_if.k, ml_if.w, ml_if.mode);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sha256();
    run(MODE_256, I1, -1, 0, -1, -1, 196);
    exp_d = model(MODE_256, I1);
    checks++;
    if (done_cyc !== 193 || n_done !== 1) begin
      errors++;
      $display("FAIL s256_done cyc=%0d n=%0d exp 193/1",
               done_cyc, n_done);
    end
    checks++;
    if (n_en !== 64) begin
      errors++;
      $display("FAIL s256_enables got=%0d exp=64", n_en);
    end
    checks++;
    if (max_rnd !== 63 || rnd_bad !== 0) begin
      errors++;
      $display("FAIL s256_rounds max=%0d bad=%0d exp 63/0",
               max_rnd, rnd_bad);
    end
    checks++;
    if (first_busy !== 1 || last_busy !== 193 || n_busy !== 193) begin
      errors++;
      $display("FAIL s256_busy first=%0d last=%0d n=%0d exp 1/193/193",
               first_busy, last_busy, n_busy);
    end
    checks++;
    if (mode_bad !== 0) begin
      errors++;
      $display("FAIL s256_mode bad_cycles=%0d exp=0", mode_bad);
    end
    checks++;
    if (digest_o !== exp_d) begin
      errors++;
      $display("FAIL s256_digest got=%h exp=%h", digest_o, exp_d);
    end
  endtask

  task automatic test_sha512();
    run(MODE_512, I2, -1, 0, -1, -1, 244);
    exp_d = model(MODE_512, I2);
    checks++;
    if (done_cyc !== 241 || n_done !== 1) begin
      errors++;
      $display("FAIL s512_done cyc=%0d n=%0d exp 241/1",
               done_cyc, n_done);
    end
    checks++;
    if (n_en !== 80 || max_rnd !== 79 || rnd_bad !== 0) begin
      errors++;
      $display("FAIL s512_rounds en=%0d max=%0d bad=%0d exp 80/79/0",
               n_en, max_rnd, rnd_bad);
    end
    checks++;
    if (mode_bad !== 0) begin
      errors++;
      $display("FAIL s512_mode bad_cycles=%0d exp=0", mode_bad);
    end
    checks++;
    if (digest_o !== exp_d) begin
      errors++;
      $display("FAIL s512_digest got=%h exp=%h", digest_o, exp_d);
    end
  endtask

  task automatic test_stall();
    run(MODE_256, I1, 10, 5, -1, -1, 200);
    exp_d = model(MODE_256, I1);
    checks++;
    if (stall_req !== 5 || stall_en !== 0) begin
      errors++;
      $display("FAIL stall_hold req=%0d en=%0d exp 5/0",
               stall_req, stall_en);
    end
    checks++;
    if (done_cyc !== 198 || n_en !== 64) begin
      errors++;
      $display("FAIL stall_done cyc=%0d en=%0d exp 198/64",
               done_cyc, n_en);
    end
    checks++;
    if (digest_o !== exp_d) begin
      errors++;
      $display("FAIL stall_digest got=%h exp=%h", digest_o, exp_d);
    end
  endtask

  task automatic test_abort_wait();
    prev_d = exp_d;
    run(MODE_256, I3, -1, 0, 93, -1, 200);
    checks++;
    if (busy_log[93] !== 1'b1 || busy_log[94] !== 1'b0) begin
      errors++;
      $display("FAIL abortw_busy c93=%b c94=%b exp 1/0",
               busy_log[93], busy_log[94]);
    end
    checks++;
    if (n_done !== 0 || max_rnd !== 30) begin
      errors++;
      $display("FAIL abortw_done n=%0d max_rnd=%0d exp 0/30",
               n_done, max_rnd);
    end
    checks++;
    if (digest_o !== prev_d) begin
      errors++;
      $display("FAIL abortw_digest got=%h exp=%h", digest_o, prev_d);
    end
    run(MODE_256, I3, -1, 0, -1, -1, 196);
    exp_d = model(MODE_256, I3);
    checks++;
    if (done_cyc !== 193 || digest_o !== exp_d) begin
      errors++;
      $display("FAIL abortw_rerun cyc=%0d exp=193 digest=%h exp=%h",
               done_cyc, digest_o, exp_d);
    end
  endtask

  task automatic test_busy_start();
    run(MODE_512, I1, -1, 0, -1, 50, 300);
    exp_d = model(MODE_512, I1);
    checks++;
    if (n_done !== 1 || done_cyc !== 241 || n_busy !== 241) begin
      errors++;
      $display("FAIL bstart_one n=%0d cyc=%0d busy=%0d exp 1/241/241",
               n_done, done_cyc, n_busy);
    end
    checks++;
    if (digest_o !== exp_d) begin
      errors++;
      $display("FAIL bstart_digest got=%h exp=%h", digest_o, exp_d);
    end
  endtask

  task automatic test_abort_done();
    prev_d = exp_d;
    run(MODE_256, I2, -1, 0, 193, -1, 230);
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL abortd_pulse n=%0d exp=0", n_done);
    end
    checks++;
    if (busy_log[193] !== 1'b1 || busy_log[194] !== 1'b0) begin
      errors++;
      $display("FAIL abortd_busy c193=%b c194=%b exp 1/0",
               busy_log[193], busy_log[194]);
    end
    checks++;
    if (digest_o !== prev_d) begin
      errors++;
      $display("FAIL abortd_digest got=%h exp=%h", digest_o, prev_d);
    end
  endtask

  task automatic test_start_abort_idle();
    run(MODE_256, I2, -1, 0, 0, -1, 196);
    exp_d = model(MODE_256, I2);
    checks++;
    if (done_cyc !== 193 || first_busy !== 1) begin
      errors++;
      $display("FAIL idleab_done cyc=%0d busy1=%0d exp 193/1",
               done_cyc, first_busy);
    end
    checks++;
    if (digest_o !== exp_d) begin
      errors++;
      $display("FAIL idleab_digest got=%h exp=%h", digest_o, exp_d);
    end
  endtask

  task automatic test_rst_mid();
    @(posedge clk); #1;
    mode_i = MODE_256;
    init_i = I1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ml_if.enable !== 1'b1 || round_o !== 7'd1) begin
      errors++;
      $display("FAIL rstmid_pre en=%b rnd=%0d exp 1/1",
               ml_if.enable, round_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ml_if.enable, busy, sched_req, done} !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_flags got=%b exp=0000",
               {ml_if.enable, busy, sched_req, done});
    end
    checks++;
    if (round_o !== '0 || digest_o !== '0) begin
      errors++;
      $display("FAIL rstmid_regs rnd=%0d digest=%h exp 0/0",
               round_o, digest_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      I1[i] = 64'h6A09E667F3BCC908 + 64'(i) * 64'h0101010101010101;
      I2[i] = 64'hCBBB9D5DC1059ED8 ^ (64'(i) << (i * 4));
      I3[i] = 64'h0123456789ABCDEF * 64'(i + 3);
    end
    test_reset();
    test_sha256();
    test_sha512();
    test_stall();
    test_abort_wait();
    test_busy_start();
    test_abort_done();
    test_start_abort_idle();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
